synth_voice: RTL and testbench
==============================

# synth_voice

Single-voice sample generator that feeds the I2S transmitter. It contains a phase-accumulator oscillator with selectable waveform and an ADSR amplitude envelope. It produces one signed 16-bit sample per sample period, DIVISOR clocks long, and holds the result stable on both channel outputs for the I2S stage to load.

## Interface
Parameters:
- DIVISOR, 512: clocks per sample period. Must equal the I2S DIVISOR.
- NUM_OF_AMPLITUDE_BITS, 16: sample width, two's complement. Block is specified for 16.
- PHASE_BITS, 24: phase accumulator width.

Ports:
- i_Clk, in, 1: system clock. Single clock domain.
- i_Rst_n, in, 1: reset, asynchronous, active-low.
- i_Gate, in, 1: note gate, level-sensitive.
- i_Phase_Inc, in, PHASE_BITS: phase increment per sample.
- i_Wave_Sel, in, 2: waveform select. 0 = saw, 1 = square, 2 = triangle, 3 = silence.
- i_Attack_Step, in, 16: envelope increment per sample in ATTACK.
- i_Decay_Step, in, 16: envelope decrement per sample in DECAY.
- i_Sustain_Level, in, 16: sustain envelope level.
- i_Release_Step, in, 16: envelope decrement per sample in RELEASE.
- o_Sample_Left, out, 16: current sample.
- o_Sample_Right, out, 16: identical to o_Sample_Left.
- o_Sample_Valid, out, 1: one-cycle pulse when a new sample is presented.
- o_Env_State, out, 3: envelope state. IDLE = 0, ATTACK = 1, DECAY = 2, SUSTAIN = 3, RELEASE = 4.
- o_Active, out, 1: high when envelope state is not IDLE.

## Operation
- **Sample counter.** Free-running, counts 0..DIVISOR-1 and wraps. A tick occurs in the cycle where count equals DIVISOR-1.
- **Trigger capture.**
  - A rising edge of i_Gate sets trig_pending. The edge is detected against a registered copy of i_Gate.
  - trig_pending is cleared on the next tick.
  - An edge arriving in the tick cycle itself is consumed by that tick.
- **Envelope.** Envelope value env is 16-bit unsigned, saturating. The FSM evaluates only on a tick; trigger has priority.
  - Trigger, from any state → ATTACK. env is kept, not reset.
  - ATTACK: env = min(env + attack_step, 0xFFFF). When env reaches 0xFFFF → DECAY.
  - DECAY: env = max(env − decay_step, sustain). When env reaches sustain → SUSTAIN.
  - SUSTAIN: env = i_Sustain_Level, so it follows live changes to that input.
  - i_Gate low while in ATTACK, DECAY or SUSTAIN → RELEASE, and the release decrement applies on the same tick.
  - RELEASE: env = max(env − release_step, 0). When env reaches 0 → IDLE.
  - IDLE: env = 0.
  - A step value of 0 holds env in the current state indefinitely. This is legal.
- **Phase.** On every tick, phase = (phase + i_Phase_Inc) mod 2^PHASE_BITS, regardless of envelope state. p is the top 16 bits of phase.
- **Waveform**, computed from the updated p:
  - Saw: p − 32768.
  - Square: +32767 if p[15] = 0, else −32768.
  - Triangle: if p[15] = 0, {p[14:0],0} − 32768; else 32767 − {p[14:0],0}.
  - Silence: 0.
- **Scaling.** sample = (wave × {0,env}) >>> 16. The signed 16 × 17 product is 33 bits; take bits [31:16], which floors toward −∞.

## Timing
- **Reset (asynchronous).** Phase 0, counter 0, env 0, state IDLE, trig_pending 0. All outputs 0.
- **Pipeline.**
  - Tick at cycle T.
  - phase, env and state registered at T+1. o_Env_State and o_Active change at T+1.
  - Samples registered and o_Sample_Valid high for one cycle at T+2.
- **Pulse spacing.** o_Sample_Valid pulses exactly every DIVISOR cycles. The first pulse is DIVISOR+1 cycles after reset release.
- **Output hold.** Samples hold between pulses.
- **Input sampling.** Control inputs are sampled at tick only, except i_Gate edge capture, which runs every cycle.
- **Reset mid-note.** Outputs clear asynchronously. First tick after release is DIVISOR cycles later.

## Structure
- **Package synth_pkg:**
  - env state encoding
  - wave select constants
  - default DIVISOR
  - sample width
- **Sub-module adsr_envelope:** trigger capture, FSM and env register.
- **Top:** counter, phase accumulator, waveform, multiply, and output registers.

## Test plan
- **Reset cadence.** Reset with DIVISOR = 8, then release → outputs 0 and o_Env_State = 0; first o_Sample_Valid at cycle 9, then every 8 cycles.
- **Saw at full attack.** Saw, i_Phase_Inc = 0x100000, attack step 0xFFFF, sustain 0xFFFF, gate high → first valid sample −28672 (p = 0x1000, env = 0xFFFF).
- **Full ADSR sequence.** attack 0x4000, decay 0x1000, sustain 0x8000, release 0x2000, gate held 20 ticks, then low → env sequence 0x4000, 0x8000, 0xC000, 0xFFFF (→ DECAY), eight decay ticks ending clamped at 0x8000 (→ SUSTAIN), then 4 release ticks to 0 (→ IDLE, o_Active = 0).
- **Retrigger mid-release.** A 1-cycle i_Gate pulse mid-RELEASE at env = 0x6000, between ticks → next tick enters ATTACK with env = 0x6000 + attack step. No reset to 0.
- **Waveform values and wrap.**
  - Square/triangle at p = 0x4000 → +32767 / 0 × env.
  - Silence → 0.
  - i_Phase_Inc = 0xFFFFFF → phase decrements by 1 per tick and wraps from 0 to 0xFFFFFF.
- **Asynchronous reset mid-SUSTAIN.** Assert i_Rst_n low mid-SUSTAIN → samples, valid and state read 0 before the next clock edge.

Source files
------------

// File: rtl/synth_voice_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared types, constants and helpers for the synth_voice
//               oscillator / ADSR envelope slice.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  localparam logic [1:0]  c_WAVE_SAW        = 2'd0;
  localparam logic [1:0]  c_WAVE_SQUARE     = 2'd1;
  localparam logic [1:0]  c_WAVE_TRIANGLE   = 2'd2;
  localparam logic [1:0]  c_WAVE_SILENCE    = 2'd3;

  localparam int          c_DEFAULT_DIVISOR = 512;
  localparam int          c_SAMPLE_W        = 16;
  localparam logic [15:0] c_ENV_MAX         = 16'hFFFF;

  // Unsigned add that clamps at full scale instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? c_ENV_MAX : sum[15:0];
  endfunction

  // Unsigned subtract that clamps at zero instead of wrapping.
  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : 16'h0000;
  endfunction

  // Raw waveform from the top 16 phase bits, full-scale signed.
  function automatic logic signed [15:0] wave_value(input logic [1:0] sel, input logic [15:0] p);
    logic [15:0]        ramp;
    logic signed [15:0] w;
    ramp = {p[14:0], 1'b0};
    w    = '0;
    case (sel)
      c_WAVE_SAW:      w = $signed(p - 16'h8000);
      c_WAVE_SQUARE:   w = p[15] ? 16'sh8000 : 16'sh7FFF;
      c_WAVE_TRIANGLE: w = p[15] ? $signed(16'h7FFF - ramp) : $signed(ramp - 16'h8000);
      default:         w = '0;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/synth_voice_if.sv
`default_nettype none
// ============================================================================
// Module      : synth_voice_if
// Description : Control / status bundle between the voice datapath and the
//               ADSR envelope generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface synth_voice_if;
  import synth_pkg::*;

  logic        tick;
  logic        gate;
  logic [15:0] attack_step;
  logic [15:0] decay_step;
  logic [15:0] sustain_level;
  logic [15:0] release_step;
  logic [15:0] env;
  env_state_t  state;

  modport master (
    output tick, gate, attack_step, decay_step, sustain_level, release_step,
    input  env, state
  );

  modport slave (
    input  tick, gate, attack_step, decay_step, sustain_level, release_step,
    output env, state
  );
endinterface
`default_nettype wire

// File: rtl/synth_voice_adsr_envelope.sv
`default_nettype none
// ============================================================================
// Module      : adsr_envelope
// Description : Gate edge capture, ADSR state machine and saturating 16-bit
//               envelope register, advanced once per sample tick.
// Revision    : 1.0 - initial release
// ============================================================================
module adsr_envelope
  import synth_pkg::*;
(
  input  wire logic    i_Clk,
  input  wire logic    i_Rst_n,
  synth_voice_if.slave bus
);

  logic        gate_q, gate_d;
  logic        trig_q, trig_d;
  env_state_t  state_q, state_d;
  logic [15:0] env_q, env_d;
  logic        rise;
  logic        trig;
  logic [15:0] attack_env, decay_env, release_env;

  assign rise      = bus.gate & ~gate_q;
  assign trig      = trig_q | rise;
  assign bus.env   = env_q;
  assign bus.state = state_q;

  // State, envelope and edge-capture registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      gate_q  <= 1'b0;
      trig_q  <= 1'b0;
      state_q <= ENV_IDLE;
      env_q   <= 16'h0000;
    end else begin
      gate_q  <= gate_d;
      trig_q  <= trig_d;
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  // Next envelope state; a trigger wins over everything, a dropped gate
  // beats the normal per-state progression and releases on the same tick.
  always_comb begin
    gate_d      = bus.gate;
    trig_d      = trig_q | rise;
    state_d     = state_q;
    env_d       = env_q;
    attack_env  = sat_add(env_q, bus.attack_step);
    decay_env   = sat_sub(env_q, bus.decay_step);
    release_env = sat_sub(env_q, bus.release_step);
    if (decay_env < bus.sustain_level) decay_env = bus.sustain_level;

    if (bus.tick) begin
      trig_d = 1'b0;
      if (trig) begin
        env_d   = attack_env;
        state_d = (attack_env == c_ENV_MAX) ? ENV_DECAY : ENV_ATTACK;
      end else begin
        case (state_q)
          ENV_IDLE: env_d = 16'h0000;
          ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN: begin
            if (!bus.gate) begin
              env_d   = release_env;
              state_d = (release_env == 16'h0000) ? ENV_IDLE : ENV_RELEASE;
            end else if (state_q == ENV_ATTACK) begin
              env_d   = attack_env;
              state_d = (attack_env == c_ENV_MAX) ? ENV_DECAY : ENV_ATTACK;
            end else if (state_q == ENV_DECAY) begin
              env_d   = decay_env;
              state_d = (decay_env == bus.sustain_level) ? ENV_SUSTAIN : ENV_DECAY;
            end else begin
              env_d   = bus.sustain_level;
            end
          end
          ENV_RELEASE: begin
            env_d   = release_env;
            state_d = (release_env == 16'h0000) ? ENV_IDLE : ENV_RELEASE;
          end
          default: begin
            env_d   = 16'h0000;
            state_d = ENV_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/synth_voice.sv
`default_nettype none
// ============================================================================
// Module      : synth_voice
// Description : Single voice: sample-rate counter, phase accumulator,
//               waveform select, envelope scaling and held stereo output.
// Revision    : 1.0 - initial release
// ============================================================================
module synth_voice
  import synth_pkg::*;
#(
  parameter int DIVISOR               = c_DEFAULT_DIVISOR,
  parameter int NUM_OF_AMPLITUDE_BITS = c_SAMPLE_W,
  parameter int PHASE_BITS            = 24
) (
  input  wire logic                              i_Clk,
  input  wire logic                              i_Rst_n,
  input  wire logic                              i_Gate,
  input  wire logic [PHASE_BITS-1:0]             i_Phase_Inc,
  input  wire logic [1:0]                        i_Wave_Sel,
  input  wire logic [15:0]                       i_Attack_Step,
  input  wire logic [15:0]                       i_Decay_Step,
  input  wire logic [15:0]                       i_Sustain_Level,
  input  wire logic [15:0]                       i_Release_Step,
  output logic signed [NUM_OF_AMPLITUDE_BITS-1:0] o_Sample_Left,
  output logic signed [NUM_OF_AMPLITUDE_BITS-1:0] o_Sample_Right,
  output logic                                   o_Sample_Valid,
  output logic [2:0]                             o_Env_State,
  output logic                                   o_Active
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CNT_W-1:0]                       count_q, count_d;
  logic [PHASE_BITS-1:0]                  phase_q, phase_d;
  logic [1:0]                             wave_sel_q, wave_sel_d;
  logic                                   tick_dly_q, tick_dly_d;
  logic                                   valid_q, valid_d;
  logic signed [NUM_OF_AMPLITUDE_BITS-1:0] sample_q, sample_d;
  logic                                   tick;
  logic signed [15:0]                     wave;
  logic signed [16:0]                     env_s;

  synth_voice_if env_bus ();

  assign tick                  = (count_q == CNT_W'(DIVISOR - 1));
  assign env_bus.tick          = tick;
  assign env_bus.gate          = i_Gate;
  assign env_bus.attack_step   = i_Attack_Step;
  assign env_bus.decay_step    = i_Decay_Step;
  assign env_bus.sustain_level = i_Sustain_Level;
  assign env_bus.release_step  = i_Release_Step;

  adsr_envelope u_envelope (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .bus     (env_bus)
  );

  // Wave and envelope are both the post-tick values, so this lines up with
  // the sample register load one cycle after the tick.
  assign wave  = wave_value(wave_sel_q, phase_q[PHASE_BITS-1 -: 16]);
  assign env_s = $signed({1'b0, env_bus.env});

  assign o_Sample_Left  = sample_q;
  assign o_Sample_Right = sample_q;
  assign o_Sample_Valid = valid_q;
  assign o_Env_State    = env_bus.state;
  assign o_Active       = (env_bus.state != ENV_IDLE);

  // Datapath registers: counter, phase, latched wave select, output stage.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_q    <= '0;
      phase_q    <= '0;
      wave_sel_q <= c_WAVE_SAW;
      tick_dly_q <= 1'b0;
      valid_q    <= 1'b0;
      sample_q   <= '0;
    end else begin
      count_q    <= count_d;
      phase_q    <= phase_d;
      wave_sel_q <= wave_sel_d;
      tick_dly_q <= tick_dly_d;
      valid_q    <= valid_d;
      sample_q   <= sample_d;
    end
  end

  // Tick-gated updates; product bits [31:16] give a floor toward minus infinity.
  always_comb begin
    count_d    = tick ? '0 : count_q + CNT_W'(1);
    phase_d    = tick ? (phase_q + i_Phase_Inc) : phase_q;
    wave_sel_d = tick ? i_Wave_Sel : wave_sel_q;
    tick_dly_d = tick;
    valid_d    = tick_dly_q;
    sample_d   = sample_q;
    if (tick_dly_q) begin
      sample_d = NUM_OF_AMPLITUDE_BITS'((33'(wave) * 33'(env_s)) >>> 16);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_synth_voice.sv
`default_nettype none
// ============================================================================
// Module      : tb_synth_voice
// Description : Directed + randomized bench for synth_voice against a
//               behavioural envelope / oscillator model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synth_voice;

  localparam int DIV = 8;
  localparam int S_IDLE = 0, S_ATTACK = 1, S_DECAY = 2, S_SUSTAIN = 3, S_RELEASE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gate = 1'b0;
  logic [23:0] inc = '0;
  logic [1:0]  wsel = '0;
  logic [15:0] atk = '0, dec = '0, sus = '0, rel = '0;
  logic signed [15:0] sl, sr;
  logic        sv;
  logic [2:0]  st;
  logic        act;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_cnt, m_phase, m_env, m_state, m_wsel, m_out;
  bit m_pend, m_gprev, m_valid, m_ticked;

  synth_voice #(.DIVISOR(DIV), .NUM_OF_AMPLITUDE_BITS(16), .PHASE_BITS(24)) dut (
    .i_Clk           (clk),
    .i_Rst_n         (rst_n),
    .i_Gate          (gate),
    .i_Phase_Inc     (inc),
    .i_Wave_Sel      (wsel),
    .i_Attack_Step   (atk),
    .i_Decay_Step    (dec),
    .i_Sustain_Level (sus),
    .i_Release_Step  (rel),
    .o_Sample_Left   (sl),
    .o_Sample_Right  (sr),
    .o_Sample_Valid  (sv),
    .o_Env_State     (st),
    .o_Active        (act)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int wave_of(input int sel, input int p);
    case (sel)
      0: return p - 32768;
      1: return (p < 32768) ? 32767 : -32768;
      2: return (p < 32768) ? (2 * p - 32768) : (32767 - 2 * (p - 32768));
      default: return 0;
    endcase
  endfunction

  function automatic int scaled(input int sel, input int ph, input int env);
    longint prod;
    prod = longint'(wave_of(sel, (ph >> 8) & 32'hFFFF)) * longint'(env);
    return int'(prod >>> 16);
  endfunction

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_env = 0; m_state = S_IDLE; m_wsel = 0; m_out = 0;
    m_pend = 0; m_gprev = 0; m_valid = 0; m_ticked = 0;
  endtask

  // Envelope rules applied once per sample period
  task automatic env_rules(input bit trig);
    int a, d, s, r;
    a = int'(atk); d = int'(dec); s = int'(sus); r = int'(rel);
    if (trig) begin
      m_env = imin(m_env + a, 65535);
      m_state = (m_env == 65535) ? S_DECAY : S_ATTACK;
    end else if (m_state == S_IDLE) begin
      m_env = 0;
    end else if (m_state == S_RELEASE || !gate) begin
      m_env = imax(m_env - r, 0);
      m_state = (m_env == 0) ? S_IDLE : S_RELEASE;
    end else if (m_state == S_ATTACK) begin
      m_env = imin(m_env + a, 65535);
      if (m_env == 65535) m_state = S_DECAY;
    end else if (m_state == S_DECAY) begin
      m_env = imax(m_env - d, s);
      if (m_env == s) m_state = S_SUSTAIN;
    end else begin
      m_env = s;
    end
  endtask

  // One clock with the model advanced alongside; returns 1 time unit after the edge
  task automatic clk_edge();
    bit is_tick, rise;
    is_tick = (m_cnt == DIV - 1);
    @(posedge clk);
    rise = gate && !m_gprev;
    m_gprev = gate;
    m_valid = m_ticked;
    if (m_ticked) m_out = scaled(m_wsel, m_phase, m_env);
    m_ticked = is_tick;
    if (is_tick) begin
      m_phase = (m_phase + int'(inc)) & 32'h00FF_FFFF;
      m_wsel = int'(wsel);
      env_rules(m_pend || rise);
      m_pend = 0;
    end else if (rise) begin
      m_pend = 1;
    end
    m_cnt = is_tick ? 0 : m_cnt + 1;
    #1;
  endtask

  // Run to the next tick, check state at T+1 and the sample at T+2
  task automatic next_tick(input string tag);
    int guard;
    guard = 0;
    do begin
      clk_edge();
      guard++;
    end while (!m_ticked && guard < 2 * DIV);
    check({tag, "_tick_seen"}, int'(m_ticked), 1);
    check({tag, "_state"}, int'(st), m_state);
    check({tag, "_active"}, int'(act), (m_state != S_IDLE) ? 1 : 0);
    clk_edge();
    check({tag, "_valid"}, int'(sv), 1);
    check({tag, "_left"}, int'(sl), m_out);
    check({tag, "_right"}, int'(sr), m_out);
  endtask

  initial begin
    int loops;
    model_reset();

    // Reset state and pulse cadence
    repeat (3) @(posedge clk);
    #1;
    check("rst_left", int'(sl), 0);
    check("rst_valid", int'(sv), 0);
    check("rst_state", int'(st), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      clk_edge();
      check($sformatf("cadence_e%0d", e), int'(sv), (e >= 9 && (e - 1) % DIV == 0) ? 1 : 0);
    end

    // Saw at full attack
    wsel = 2'd0; inc = 24'h100000; atk = 16'hFFFF; sus = 16'hFFFF; dec = 16'h0; rel = 16'h0;
    gate = 1'b1;
    next_tick("saw_attack");
    check("saw_first_const", int'(sl), -28672);
    next_tick("saw_sustain");
    gate = 1'b0; rel = 16'hFFFF;
    next_tick("saw_release");

    // Full ADSR sequence on a square wave
    inc = 24'h0; wsel = 2'd1;
    atk = 16'h4000; dec = 16'h1000; sus = 16'h8000; rel = 16'h2000;
    gate = 1'b1;
    for (int i = 0; i < 20; i++) next_tick($sformatf("adsr_on%0d", i));
    check("adsr_in_sustain", int'(st), S_SUSTAIN);
    gate = 1'b0;
    for (int i = 0; i < 4; i++) next_tick($sformatf("adsr_rel%0d", i));
    check("adsr_idle_active", int'(act), 0);

    // Retrigger mid-release: short pulse between ticks keeps env
    gate = 1'b1;
    for (int i = 0; i < 12; i++) next_tick($sformatf("rt_on%0d", i));
    gate = 1'b0;
    next_tick("rt_rel");
    clk_edge(); clk_edge();
    gate = 1'b1;
    clk_edge();
    gate = 1'b0;
    next_tick("rt_attack");
    check("rt_attack_state", int'(st), S_ATTACK);
    next_tick("rt_after");
    loops = 0;
    while (m_state != S_IDLE && loops < 40) begin next_tick("rt_drain"); loops++; end

    // Waveform values at p = 0x4000, then silence, then phase wrap
    atk = 16'hFFFF; dec = 16'h0; sus = 16'hC000; rel = 16'h1000;
    gate = 1'b1; wsel = 2'd1;
    inc = 24'(32'h0040_0000 - m_phase);
    next_tick("wv_square");
    check("wv_square_const", int'(sl), 32766);
    inc = 24'h0; wsel = 2'd2;
    next_tick("wv_triangle");
    check("wv_triangle_const", int'(sl), 0);
    wsel = 2'd3;
    next_tick("wv_silence");
    check("wv_silence_const", int'(sl), 0);
    wsel = 2'd0;
    inc = 24'(32'h0100_0000 - m_phase);
    next_tick("wrap_zero");
    inc = 24'hFFFFFF;
    next_tick("wrap_under");
    next_tick("wrap_dec");

    // Randomized controls and gate activity
    for (int i = 0; i < 24; i++) begin
      inc  = 24'($urandom);
      wsel = 2'($urandom);
      atk  = 16'($urandom_range(0, 65535));
      dec  = 16'($urandom_range(0, 16384));
      sus  = 16'($urandom);
      rel  = 16'($urandom_range(0, 16384));
      gate = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        clk_edge();
        gate = ~gate;
      end
      next_tick($sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of a sustained note
    wsel = 2'd1; inc = 24'h0; atk = 16'h8000; dec = 16'h4000; sus = 16'h8000; rel = 16'h1000;
    gate = 1'b0;
    next_tick("ar_prep");
    gate = 1'b1;
    loops = 0;
    while (m_state != S_SUSTAIN && loops < 10) begin next_tick("ar_climb"); loops++; end
    next_tick("ar_hold");
    check("ar_in_sustain", int'(st), S_SUSTAIN);
    check("ar_nonzero", (sl != 0) ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_left", int'(sl), 0);
    check("ar_right", int'(sr), 0);
    check("ar_valid", int'(sv), 0);
    check("ar_state", int'(st), 0);
    check("ar_active", int'(act), 0);
    @(negedge clk);
    gate = 1'b0;
    rst_n = 1'b1;
    model_reset();
    next_tick("ar_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
